axis_dest_router: RTL and testbench

//  Egress-side counterpart of the switch arbitration path: one AXI-Stream slave fanned out to N master ports.

---
 rtl/axis_switch_pkg.sv | 24 ++
 rtl/axis_pipe_reg.sv | 38 +++
 rtl/axis_dest_router.sv | 136 +++++++++++++
 tb/tb_axis_dest_router.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_switch_pkg.sv
// Shared types for the AXI-Stream switch egress path: router FSM states, beat record, id-width helper.
package axis_switch_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_DEST_W = 4;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } router_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_DEST_W-1:0] dest;
    logic                   last;
  } axis_beat_t;

  // Width of a port index; never zero so a 1-port corner still elaborates.
  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-deep valid/ready register carrying a beat and its destination port id.
module axis_pipe_reg
  import axis_switch_pkg::*;
#(
  parameter type beat_t = axis_beat_t,
  parameter int  ID_W   = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  beat_t           in_beat,
  input  logic [ID_W-1:0] in_id,
  input  logic            in_vld,
  output logic            in_rdy,
  output beat_t           out_beat,
  output logic [ID_W-1:0] out_id,
  output logic            out_vld,
  input  logic            out_rdy
);

  assign in_rdy = !out_vld || out_rdy;

  // NOTE: payload is reset as well so the shared m_* buses read zero after reset,
  // and it only loads on a real beat so it stays stable while a stall is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld  <= 1'b0;
      out_beat <= '0;
      out_id   <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_beat <= in_beat;
        out_id   <= in_id;
      end
    end
  end

endmodule

// File: rtl/axis_dest_router.sv
// Routes whole AXI-Stream packets by the head beat's tdest to one of N_PORTS masters.
// Optional feature: define AXIS_ROUTER_DROP_EN to drop out-of-range packets and count them.
module axis_dest_router
  import axis_switch_pkg::*;
#(
  parameter int N_PORTS = 6,
  parameter int DATA_W  = AXIS_DATA_W,
  parameter int DEST_W  = AXIS_DEST_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic [DEST_W-1:0]  s_tdest,
  input  logic               s_tlast,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [DATA_W-1:0]  m_tdata,
  output logic [DEST_W-1:0]  m_tdest,
  output logic               m_tlast,
  output logic [N_PORTS-1:0] m_tvalid,
  input  logic [N_PORTS-1:0] m_tready,
  output logic               busy_o
`ifdef AXIS_ROUTER_DROP_EN
  ,
  output logic [CNT_W-1:0]   drop_cnt_o
`endif
);

  localparam int ID_W = port_id_w(N_PORTS);

  if (N_PORTS < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("axis_dest_router: N_PORTS must be >= 2 and CNT_W >= 1");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              last;
  } beat_t;

  router_state_t   state;
  logic [ID_W-1:0] route_id, head_id, sel_id, out_id;
  logic [DEST_W-1:0] head_dest;
  logic            is_head, dest_oor, drop_now, accept;
  logic            pipe_in_rdy, pipe_out_rdy, out_vld;
  beat_t           in_beat, out_beat;

  assign is_head  = (state == HEAD);
  assign dest_oor = int'(s_tdest) >= N_PORTS;
  assign head_id  = dest_oor ? ID_W'(N_PORTS - 1) : ID_W'(s_tdest);
  assign sel_id   = is_head ? head_id : route_id;

  // m_tdest reports the head's destination for every beat of the packet.
  assign in_beat = '{data: s_tdata, dest: (is_head ? s_tdest : head_dest), last: s_tlast};

`ifdef AXIS_ROUTER_DROP_EN
  assign drop_now = (is_head && dest_oor) || (state == DROP);
`else
  assign drop_now = 1'b0;
`endif

  assign s_tready     = drop_now || pipe_in_rdy;
  assign accept       = s_tvalid && s_tready;
  assign pipe_out_rdy = m_tready[out_id];

  axis_pipe_reg #(
    .beat_t (beat_t),
    .ID_W   (ID_W)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_beat  (in_beat),
    .in_id    (sel_id),
    .in_vld   (s_tvalid && !drop_now),
    .in_rdy   (pipe_in_rdy),
    .out_beat (out_beat),
    .out_id   (out_id),
    .out_vld  (out_vld),
    .out_rdy  (pipe_out_rdy)
  );

  assign m_tdata = out_beat.data;
  assign m_tdest = out_beat.dest;
  assign m_tlast = out_beat.last;
  assign busy_o  = !is_head;

  // NOTE: default assignment first so the loop can never leave a bit unassigned (no latch).
  always_comb begin
    m_tvalid = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      m_tvalid[i] = out_vld && (out_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HEAD;
      route_id  <= '0;
      head_dest <= '0;
    end else if (accept) begin
      unique case (state)
        HEAD: begin
          route_id  <= head_id;
          head_dest <= s_tdest;
          if (!s_tlast) state <= drop_now ? DROP : BODY;
        end
        BODY, DROP: if (s_tlast) state <= HEAD;
        default:    state <= HEAD;
      endcase
    end
  end

`ifdef AXIS_ROUTER_DROP_EN
  logic [CNT_W-1:0] drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (accept && drop_now && s_tlast && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(m_tvalid));

  a_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_vld && !pipe_out_rdy) |=> (out_vld && $stable(out_beat) && $stable(out_id)));

  a_route: assert property (@(posedge clk) disable iff (!reset_n)
    (state == BODY) |=> $stable(route_id));

endmodule

// File: tb/tb_axis_dest_router.sv
// Self-checking bench for axis_dest_router: vector table plus scoreboard, and stall/reset sequences.
module tb_axis_dest_router;

  localparam int N_PORTS = 6;
  localparam int NO_PORT = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_tdata;
  logic [3:0]  s_tdest;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tdest;
  logic        m_tlast;
  logic [5:0]  m_tvalid, m_tready;
  logic        busy_o;
  logic [15:0] drop_cnt_o;

  always #5 clk = ~clk;

  axis_dest_router #(
    .N_PORTS (N_PORTS), .DATA_W (32), .DEST_W (4), .CNT_W (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tdest  (s_tdest),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tdest  (m_tdest),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .busy_o   (busy_o)
`ifdef AXIS_ROUTER_DROP_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

`ifndef AXIS_ROUTER_DROP_EN
  assign drop_cnt_o = '0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
    int          port;     // expected output port, NO_PORT when dropped
    logic [3:0]  exp_dest; // expected m_tdest
    logic        exp_busy; // busy_o after the beat is accepted
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
    int          port;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every master handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (reset_n && ((m_tvalid & m_tready) != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(m_tvalid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("m_tvalid", 64'(m_tvalid), 64'(6'd1 << mon_e.port));
        check("m_tdata", 64'(m_tdata), 64'(mon_e.data));
        check("m_tdest", 64'(m_tdest), 64'(mon_e.dest));
        check("m_tlast", 64'(m_tlast), 64'(mon_e.last));
      end
    end
  end

  // Drive one beat, wait for the handshake (bounded) and register the expectation.
  task automatic send_beat(input vec_t v, output int waits);
    logic rdy;
    s_tdata  = v.data;
    s_tdest  = v.dest;
    s_tlast  = v.last;
    s_tvalid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        check("s_tready_timeout", 64'(s_tready), 64'd1);
        break;
      end
    end
    if (v.port != NO_PORT) sb.push_back('{data: v.data, dest: v.exp_dest, last: v.last, port: v.port});
    s_tvalid = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t v;
  int   waits;
  int   oor_port;

  initial begin
`ifdef AXIS_ROUTER_DROP_EN
    oor_port = NO_PORT;
`else
    oor_port = N_PORTS - 1;
`endif
    // 3-beat to port 2; dest change mid-packet; back-to-back singles; out-of-range 2-beat.
    vecs[0] = '{32'hA000_0001, 4'd2, 1'b0, 2, 4'd2, 1'b1};
    vecs[1] = '{32'hA000_0002, 4'd2, 1'b0, 2, 4'd2, 1'b1};
    vecs[2] = '{32'hA000_0003, 4'd2, 1'b1, 2, 4'd2, 1'b0};
    vecs[3] = '{32'hB000_0001, 4'd1, 1'b0, 1, 4'd1, 1'b1};
    vecs[4] = '{32'hB000_0002, 4'd4, 1'b1, 1, 4'd1, 1'b0};
    vecs[5] = '{32'hC000_0000, 4'd0, 1'b1, 0, 4'd0, 1'b0};
    vecs[6] = '{32'hC000_0005, 4'd5, 1'b1, 5, 4'd5, 1'b0};
    vecs[7] = '{32'hC000_0003, 4'd3, 1'b1, 3, 4'd3, 1'b0};
    vecs[8] = '{32'hD000_0001, 4'd9, 1'b0, oor_port, 4'd9, 1'b1};
    vecs[9] = '{32'hD000_0002, 4'd9, 1'b1, oor_port, 4'd9, 1'b0};

    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tdest  = '0;
    s_tlast  = 1'b0;
    m_tready = '1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tdest", 64'(m_tdest), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    @(posedge clk);
    #1;

    // Table: all ports ready, so every beat must be taken without a wait cycle.
    for (int i = 0; i < 10; i++) begin
      send_beat(vecs[i], waits);
      check($sformatf("vec%0d_waits", i), 64'(waits), 64'd0);
      check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].exp_busy));
    end
    @(negedge clk);
`ifdef AXIS_ROUTER_DROP_EN
    check("drop_cnt_after_oor", 64'(drop_cnt_o), 64'd1);
`endif
    @(posedge clk);
    #1;

    // Head-of-line stall on port 4 for 5 cycles.
    m_tready = 6'b101111;
    v = '{32'hE000_0001, 4'd4, 1'b0, 4, 4'd4, 1'b1};
    send_beat(v, waits);
    check("stall_head_waits", 64'(waits), 64'd0);
    s_tdata  = 32'hE000_0002;
    s_tdest  = 4'd4;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_s_tready", 64'(s_tready), 64'd0);
      check("stall_m_tvalid", 64'(m_tvalid), 64'b010000);
      check("stall_m_tdata", 64'(m_tdata), 64'hE000_0001);
      @(posedge clk);
      #1;
    end
    m_tready = '1;
    @(negedge clk);
    check("unstall_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    sb.push_back('{data: 32'hE000_0002, dest: 4'd4, last: 1'b1, port: 4});
    s_tvalid = 1'b0;
    check("stall_busy_end", 64'(busy_o), 64'd0);

    // Reset after beat 2 of 4; remaining beats form a new packet led by a re-sampled tdest.
    v = '{32'hF000_0001, 4'd3, 1'b0, 3, 4'd3, 1'b1};
    send_beat(v, waits);
    v = '{32'hF000_0002, 4'd3, 1'b0, 3, 4'd3, 1'b1};
    send_beat(v, waits);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_m_tdata", 64'(m_tdata), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    v = '{32'hF000_0003, 4'd0, 1'b0, 0, 4'd0, 1'b1};
    send_beat(v, waits);
    check("postrst_head_busy", 64'(busy_o), 64'd1);
    v = '{32'hF000_0004, 4'd2, 1'b1, 0, 4'd0, 1'b0};
    send_beat(v, waits);
    check("postrst_tail_busy", 64'(busy_o), 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
